// File: rtl/tetris_input_sched_if.sv
// tetris_input_sched_if
//   Command-side bundle for the input scheduler.
//   enable     : game active; low flushes the scheduler
//   press      : one-cycle press pulses {rot, down, left, right}
//   rel        : one-cycle release pulses, same bit order.
//                ("release" is a reserved word, hence the short name.)
//   cmd_valid  : command available
//   cmd_code   : 3 = rotate, 2 = down, 1 = left, 0 = right
//   cmd_ready  : consumer accepts on cmd_valid && cmd_ready at the clk edge
//   master = debouncers + game FSM side, slave = scheduler.
interface tetris_input_sched_if;
   logic       enable;
   logic [3:0] press;
   logic [3:0] rel;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic       cmd_ready;

   modport master (output enable, press, rel, cmd_ready,
                   input  cmd_valid, cmd_code);
   modport slave  (input  enable, press, rel, cmd_ready,
                   output cmd_valid, cmd_code);
endinterface

// File: rtl/tetris_input_sched.sv
// tetris_input_sched
//   Turns debounced press/release pulses of four buttons into a single
//   stream of move commands with delayed auto-shift (DAS) and auto-repeat
//   (ARR), arbitrated by fixed priority rot > down > left > right and
//   handed out over a valid/ready handshake.
//
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     bus    : tetris_input_sched_if.slave (enable, press, rel,
//              cmd_valid, cmd_code, cmd_ready)
//
//   Optional feature macro: INPUT_SCHED_LASTWIN_EN
//     defined   : left/right are mutually exclusive, the newest press wins
//                 (left wins a same-cycle tie); the loser's FSM and pending
//                 bit are cleared.
//     undefined : left and right run fully independent FSMs.

// Per-button DAS/ARR state machine with its one-deep pending bit.
module tetris_btn_fsm #(
   parameter int unsigned DAS_TICKS = 16,
   parameter int unsigned ARR_TICKS = 4,
   parameter bit          REPEAT_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic tick,
   input  logic press,
   input  logic rel,
   input  logic kill,    // forced flush from the other side of a left/right pair
   input  logic grant,   // arbiter took this button's pending request
   output logic pend
);
   typedef enum logic [1:0] {IDLE, DAS, REPEAT} state_t;

   state_t     state;
   logic [7:0] cnt;
   logic       fire;
   logic       set_evt;

   // A timer expiry only creates an event if the button is not being let go
   // in the same cycle; press always creates one.
   assign fire    = tick && (state != IDLE) && (cnt == 8'd1);
   assign set_evt = press || (!rel && fire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
         pend  <= 1'b0;
      end else if (!enable || kill) begin
         state <= IDLE;
         cnt   <= 8'd0;
         pend  <= 1'b0;
      end else begin
         // set beats grant: a new event arriving while the old one is taken
         // must still be delivered.
         pend <= set_evt || (pend && !grant);
         if (press) begin
            // press wins over a simultaneous release; also restarts DAS
            if (REPEAT_EN) begin
               state <= DAS;
               cnt   <= 8'(DAS_TICKS);
            end
         end else if (rel) begin
            state <= IDLE;
            cnt   <= 8'd0;
         end else if (tick && state != IDLE) begin
            if (cnt == 8'd1) begin
               state <= REPEAT;
               cnt   <= 8'(ARR_TICKS);
            end else begin
               cnt <= cnt - 8'd1;
            end
         end
      end
   end
endmodule

module tetris_input_sched #(
   parameter int unsigned TICK_DIV    = 250000,
   parameter int unsigned DAS_TICKS   = 16,
   parameter int unsigned ARR_TICKS   = 4,
   parameter logic [3:0]  REPEAT_MASK = 4'b0111
) (
   input  logic                 clk,
   input  logic                 rst_n,
   tetris_input_sched_if.slave  bus
);
   localparam int NUM_BTN = 4;
   localparam int PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0]      presc;
   logic               tick;
   logic [NUM_BTN-1:0] pend;
   logic [NUM_BTN-1:0] grant;
   logic [NUM_BTN-1:0] kill;
   logic [1:0]         pick;
   logic               any;
   logic               load;
   logic               valid_q;
   logic [1:0]         code_q;

   // Timing prescaler; free-running, independent of enable.
   assign tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

`ifdef INPUT_SCHED_LASTWIN_EN
   // bit 1 = left, bit 0 = right; left wins a same-cycle tie
   assign kill = {2'b00, bus.press[0] && !bus.press[1], bus.press[1]};
`else
   assign kill = '0;
`endif

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      tetris_btn_fsm #(
         .DAS_TICKS (DAS_TICKS),
         .ARR_TICKS (ARR_TICKS),
         .REPEAT_EN (REPEAT_MASK[i])
      ) u_btn (
         .clk    (clk),
         .rst_n  (rst_n),
         .enable (bus.enable),
         .tick   (tick),
         .press  (bus.press[i]),
         .rel    (bus.rel[i]),
         .kill   (kill[i]),
         .grant  (grant[i]),
         .pend   (pend[i])
      );
   end

   // Fixed priority: highest index wins (ascending scan, last hit kept).
   always_comb begin
      pick = 2'd0;
      for (int i = 0; i < NUM_BTN; i++)
         if (pend[i]) pick = 2'(i);
   end

   assign any   = |pend;
   assign load  = !valid_q || bus.cmd_ready;
   assign grant = (bus.enable && load && any) ? (4'(1) << pick) : '0;

   // Output register; holds code stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         code_q  <= 2'd0;
      end else if (!bus.enable) begin
         // flush without waiting for a handshake
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q <= any;
         if (any) code_q <= pick;
      end
   end

   assign bus.cmd_valid = valid_q;
   assign bus.cmd_code  = code_q;
endmodule

// File: tb/tb_tetris_input_sched.sv
// tb_tetris_input_sched
//   Self-checking bench for tetris_input_sched: a table of per-cycle
//   vectors, hand-written multi-cycle sequences and randomized traffic,
//   all compared against a tick-counting reference model.
module tb_tetris_input_sched;
   localparam int         TICK_DIV  = 4;
   localparam int         DAS       = 3;
   localparam int         ARR       = 2;
   localparam logic [3:0] RMASK     = 4'b0111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   always #5 clk = ~clk;

   tetris_input_sched_if bus();

   tetris_input_sched #(
      .TICK_DIV    (TICK_DIV),
      .DAS_TICKS   (DAS),
      .ARR_TICKS   (ARR),
      .REPEAT_MASK (RMASK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_hs   = 0;

   // reference model: buttons are "held" or not; a held repeating button
   // emits at elapsed tick counts DAS, DAS+ARR, DAS+2*ARR, ...
   int         m_presc;
   logic [3:0] m_held;
   int         m_el [4];
   logic [3:0] m_pend;
   logic       m_valid;
   logic [1:0] m_code;

   typedef struct {
      logic [3:0] p;
      logic [3:0] r;
      logic       rdy;
      logic       ev;
      logic [1:0] ec;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_presc = 0;
      m_held  = '0;
      m_pend  = '0;
      m_valid = 1'b0;
      m_code  = 2'd0;
      for (int i = 0; i < 4; i++) m_el[i] = 0;
   endtask

   task automatic model_edge(input logic [3:0] p, input logic [3:0] r,
                             input logic rdy, input logic e);
      logic       tk;
      logic [3:0] set;
      int         g;
      tk      = (m_presc == TICK_DIV - 1);
      m_presc = (m_presc + 1) % TICK_DIV;
      if (!e) begin
         m_held  = '0;
         m_pend  = '0;
         m_valid = 1'b0;
         return;
      end
      g = -1;
      if (!m_valid || rdy) begin
         m_valid = 1'b0;
         for (int i = 3; i >= 0; i--)
            if (m_pend[i] && g < 0) g = i;
         if (g >= 0) begin
            m_valid = 1'b1;
            m_code  = 2'(g);
         end
      end
      set = '0;
      for (int i = 0; i < 4; i++) begin
         if (p[i]) begin
            set[i]    = 1'b1;
            m_held[i] = RMASK[i];
            m_el[i]   = 0;
         end else if (r[i]) begin
            m_held[i] = 1'b0;
         end else if (m_held[i] && tk) begin
            m_el[i]++;
            if (m_el[i] >= DAS && (m_el[i] - DAS) % ARR == 0) set[i] = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (set[i])      m_pend[i] = 1'b1;
         else if (g == i) m_pend[i] = 1'b0;
      end
`ifdef INPUT_SCHED_LASTWIN_EN
      if (p[1]) begin
         m_held[0] = 1'b0;
         m_pend[0] = 1'b0;
      end else if (p[0]) begin
         m_held[1] = 1'b0;
         m_pend[1] = 1'b0;
      end
`endif
   endtask

   // One clock: drive at negedge, count the handshake taken at the coming
   // edge, advance the model, compare at the next negedge.
   task automatic cyc(input logic [3:0] p, input logic [3:0] r, input logic rdy);
      bus.press     = p;
      bus.rel       = r;
      bus.cmd_ready = rdy;
      bus.enable    = en;
      #1;
      if (rst_n && bus.cmd_valid && rdy) n_hs++;
      @(posedge clk);
      if (rst_n) model_edge(p, r, rdy, en);
      @(negedge clk);
      check("model_valid", int'(bus.cmd_valid), int'(m_valid));
      if (m_valid) check("model_code", int'(bus.cmd_code), int'(m_code));
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(4'b0, 4'b0, rdy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      bus.enable    = 1'b1;
      bus.press     = '0;
      bus.rel       = '0;
      bus.cmd_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_valid", int'(bus.cmd_valid), 0);
      check("reset_code", int'(bus.cmd_code), 0);
      rst_n = 1'b1;
      idle(3, 1'b1);

      // ---- table: single tap, then all four with backpressure ----
      tbl.push_back('{4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0});
      tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1});
      tbl.push_back('{4'b0000, 4'b0010, 1'b1, 1'b0, 2'd0});
      tbl.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0});
      tbl.push_back('{4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0});
      tbl.push_back('{4'b0000, 4'b1111, 1'b0, 1'b1, 2'd3});
      for (int i = 0; i < 19; i++) tbl.push_back('{4'b0, 4'b0, 1'b0, 1'b1, 2'd3});
      tbl.push_back('{4'b0, 4'b0, 1'b1, 1'b1, 2'd2});
      tbl.push_back('{4'b0, 4'b0, 1'b1, 1'b1, 2'd1});
`ifdef INPUT_SCHED_LASTWIN_EN
      tbl.push_back('{4'b0, 4'b0, 1'b1, 1'b0, 2'd0});
`else
      tbl.push_back('{4'b0, 4'b0, 1'b1, 1'b1, 2'd0});
`endif
      tbl.push_back('{4'b0, 4'b0, 1'b1, 1'b0, 2'd0});
      tbl.push_back('{4'b0, 4'b0, 1'b1, 1'b0, 2'd0});
      foreach (tbl[k]) begin
         cyc(tbl[k].p, tbl[k].r, tbl[k].rdy);
         check($sformatf("tbl%0d_valid", k), int'(bus.cmd_valid), int'(tbl[k].ev));
         if (tbl[k].ev) check($sformatf("tbl%0d_code", k), int'(bus.cmd_code), int'(tbl[k].ec));
      end

      // ---- hold left: first + 4 repeats in 40 held cycles, none after ----
      idle(4, 1'b1);
      hs0 = n_hs;
      cyc(4'b0010, 4'b0, 1'b1);
      idle(40, 1'b1);
      cyc(4'b0, 4'b0010, 1'b1);
      check("hold_left_cmds", n_hs - hs0, 5);
      hs0 = n_hs;
      idle(20, 1'b1);
      check("after_release_cmds", n_hs - hs0, 0);

      // ---- hold rotate: never repeats ----
      hs0 = n_hs;
      cyc(4'b1000, 4'b0, 1'b1);
      idle(40, 1'b1);
      cyc(4'b0, 4'b1000, 1'b1);
      idle(10, 1'b1);
      check("hold_rot_cmds", n_hs - hs0, 1);

      // ---- async reset while left repeats under backpressure ----
      cyc(4'b0010, 4'b0, 1'b0);
      idle(30, 1'b0);
      check("pre_rst_valid", int'(bus.cmd_valid), 1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_valid", int'(bus.cmd_valid), 0);
      model_reset();
      @(negedge clk);
      cyc(4'b0, 4'b0, 1'b1);
      rst_n = 1'b1;
      hs0 = n_hs;
      idle(40, 1'b1);
      check("post_rst_cmds", n_hs - hs0, 0);

      // ---- right held in REPEAT under backpressure: coalesces to one ----
      hs0 = n_hs;
      cyc(4'b0001, 4'b0, 1'b0);
      idle(40, 1'b0);
      cyc(4'b0, 4'b0001, 1'b1);
      idle(20, 1'b1);
      check("coalesce_cmds", n_hs - hs0, 2);

      // ---- enable low for one cycle mid-hold ----
      cyc(4'b0001, 4'b0, 1'b1);
      idle(15, 1'b1);
      en = 1'b0;
      cyc(4'b0, 4'b0, 1'b1);
      check("disable_valid", int'(bus.cmd_valid), 0);
      en = 1'b1;
      hs0 = n_hs;
      idle(40, 1'b1);
      check("post_disable_cmds", n_hs - hs0, 0);
      cyc(4'b0, 4'b0001, 1'b1);
      cyc(4'b0001, 4'b0, 1'b1);
      cyc(4'b0, 4'b0001, 1'b1);
      check("fresh_press_valid", int'(bus.cmd_valid), 1);
      check("fresh_press_code", int'(bus.cmd_code), 0);
      idle(3, 1'b1);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] p, r;
         for (int b = 0; b < 4; b++) begin
            p[b] = ($urandom_range(0, 15) == 0);
            r[b] = ($urandom_range(0, 7) == 0);
         end
         en = ($urandom_range(0, 63) != 0);
         cyc(p, r, ($urandom_range(0, 3) != 0));
      end
      en = 1'b1;
      idle(2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
